// File: rtl/accelerator_dnc_pkg.sv
// Shared types and constants for the DNC read-heads accelerator blocks.
package accelerator_dnc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        FEED,
        DRAIN,
        FINISH,
        FAULT
    } state_t;

    localparam int unsigned THREE_DATA = 3;
    localparam logic        ZERO       = 1'b0;
    localparam logic        ONE        = 1'b1;

    localparam int unsigned     MODE_W    = 2;
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(THREE_DATA - 1);

endpackage

// File: rtl/accelerator_read_modes_scheduler_if.sv
// Job control, upstream score stream, engine link and tagged result stream of the read-modes scheduler.
interface accelerator_read_modes_scheduler_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
);
    logic                    START;
    logic [DATA_SIZE-1:0]    SIZE_R_IN;
    logic                    BUSY;
    logic                    DONE;
    logic                    ERROR;
    logic                    PI_IN_VALID;
    logic                    PI_IN_READY;
    logic [DATA_SIZE-1:0]    PI_IN_DATA;
    logic                    ENGINE_START;
    logic                    ENGINE_READY;
    logic                    ENGINE_IN_I_ENABLE;
    logic                    ENGINE_IN_P_ENABLE;
    logic [DATA_SIZE-1:0]    ENGINE_PI_IN;
    logic                    ENGINE_OUT_I_ENABLE;
    logic                    ENGINE_OUT_P_ENABLE;
    logic [DATA_SIZE-1:0]    ENGINE_PI_OUT;
    logic                    PI_OUT_VALID;
    logic [DATA_SIZE-1:0]    PI_OUT_DATA;
    logic [CONTROL_SIZE-1:0] PI_OUT_HEAD;
    logic [1:0]              PI_OUT_MODE;

    modport master (
        input  START, SIZE_R_IN, PI_IN_VALID, PI_IN_DATA, ENGINE_READY,
               ENGINE_OUT_I_ENABLE, ENGINE_OUT_P_ENABLE, ENGINE_PI_OUT,
        output BUSY, DONE, ERROR, PI_IN_READY, ENGINE_START, ENGINE_IN_I_ENABLE,
               ENGINE_IN_P_ENABLE, ENGINE_PI_IN, PI_OUT_VALID, PI_OUT_DATA,
               PI_OUT_HEAD, PI_OUT_MODE
    );

    modport slave (
        output START, SIZE_R_IN, PI_IN_VALID, PI_IN_DATA, ENGINE_READY,
               ENGINE_OUT_I_ENABLE, ENGINE_OUT_P_ENABLE, ENGINE_PI_OUT,
        input  BUSY, DONE, ERROR, PI_IN_READY, ENGINE_START, ENGINE_IN_I_ENABLE,
               ENGINE_IN_P_ENABLE, ENGINE_PI_IN, PI_OUT_VALID, PI_OUT_DATA,
               PI_OUT_HEAD, PI_OUT_MODE
    );

endinterface

// File: rtl/accelerator_read_modes_index_counter.sv
// (head, mode) walker: mode cycles 0..2, head advances on mode wrap; last flags (R-1, 2).
module accelerator_read_modes_index_counter
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    adv_i,
    input  logic [DATA_SIZE-1:0]    size_r_i,
    output logic [CONTROL_SIZE-1:0] head_o,
    output logic [MODE_W-1:0]       mode_o,
    output logic                    last_o
);
    // One spare bit so head+1 never wraps before the compare with R.
    localparam int CW = ((CONTROL_SIZE > DATA_SIZE) ? CONTROL_SIZE : DATA_SIZE) + 1;

    logic [CONTROL_SIZE-1:0] head_q, head_d;
    logic [MODE_W-1:0]       mode_q, mode_d;

    always_comb begin
        head_d = head_q;
        mode_d = mode_q;
        if (clr_i) begin
            head_d = '0;
            mode_d = '0;
        end else if (adv_i) begin
            if (mode_q == MODE_LAST) begin
                mode_d = '0;
                head_d = head_q + CONTROL_SIZE'(ONE);
            end else begin
                mode_d = mode_q + MODE_W'(ONE);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            mode_q <= '0;
        end else begin
            head_q <= head_d;
            mode_q <= mode_d;
        end
    end

    assign head_o = head_q;
    assign mode_o = mode_q;
    assign last_o = (mode_q == MODE_LAST) && ((CW'(head_q) + CW'(ONE)) == CW'(size_r_i));

endmodule

// File: rtl/accelerator_read_modes_scheduler.sv
// Streams R x 3 read-mode scores into the shared softmax engine and tags its results with (head, mode).
module accelerator_read_modes_scheduler
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int TIMEOUT      = 1024
) (
    input  logic CLK,
    input  logic RST,
    accelerator_read_modes_scheduler_if.master bus
);
    localparam int CNT_W = DATA_SIZE + 2;
    localparam int TW    = $clog2(TIMEOUT) + 1;

    state_t                  state_q;
    logic                    busy_q, done_q, err_q, in_ready_q;
    logic                    eng_start_q, eng_i_en_q, eng_p_en_q, out_vld_q;
    logic [DATA_SIZE-1:0]    eng_pi_q, out_data_q, r_q;
    logic [CONTROL_SIZE-1:0] out_head_q;
    logic [MODE_W-1:0]       out_mode_q;
    logic [CNT_W-1:0]        target_q, out_cnt_q;
    logic [TW-1:0]           idle_q;

    logic                    start_acc, in_xfer, res_en, mode_bad, all_out, overrun;
    logic                    complete_now, timeout_hit, fault_now, in_last, out_last;
    logic [CONTROL_SIZE-1:0] in_head_unused, out_head;
    logic [MODE_W-1:0]       in_mode, out_mode;

    accelerator_read_modes_index_counter #(
        .DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE)
    ) u_in_cnt (
        .clk_i(CLK), .rst_i(RST), .clr_i(start_acc), .adv_i(in_xfer), .size_r_i(r_q),
        .head_o(in_head_unused), .mode_o(in_mode), .last_o(in_last)
    );

    accelerator_read_modes_index_counter #(
        .DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE)
    ) u_out_cnt (
        .clk_i(CLK), .rst_i(RST), .clr_i(start_acc), .adv_i(res_en && !all_out), .size_r_i(r_q),
        .head_o(out_head), .mode_o(out_mode), .last_o(out_last)
    );

    assign start_acc    = (state_q == IDLE) && bus.START && !busy_q;
    assign in_xfer      = (state_q == FEED) && in_ready_q && bus.PI_IN_VALID;
    assign res_en       = ((state_q == FEED) || (state_q == DRAIN)) && bus.ENGINE_OUT_P_ENABLE;
    assign mode_bad     = res_en && (bus.ENGINE_OUT_I_ENABLE != (out_mode == '0));
    assign all_out      = (out_cnt_q == target_q);
    assign overrun      = res_en && all_out;
    // A result arriving together with ENGINE_READY counts toward completion.
    assign complete_now = all_out || (res_en && out_last);
    assign timeout_hit  = !res_en && !bus.ENGINE_READY && (idle_q == TW'(TIMEOUT - 1));
    assign fault_now    = ((state_q == FEED) && (mode_bad || overrun || bus.ENGINE_READY)) ||
                          ((state_q == DRAIN) && (mode_bad || overrun || timeout_hit ||
                                                  (bus.ENGINE_READY && !complete_now)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            busy_q      <= ZERO;
            done_q      <= ZERO;
            err_q       <= ZERO;
            in_ready_q  <= ZERO;
            eng_start_q <= ZERO;
            eng_i_en_q  <= ZERO;
            eng_p_en_q  <= ZERO;
            out_vld_q   <= ZERO;
            eng_pi_q    <= '0;
            out_data_q  <= '0;
            out_head_q  <= '0;
            out_mode_q  <= '0;
            r_q         <= '0;
            target_q    <= '0;
            out_cnt_q   <= '0;
            idle_q      <= '0;
        end else begin
            eng_start_q <= ZERO;
            eng_i_en_q  <= ZERO;
            eng_p_en_q  <= ZERO;
            out_vld_q   <= ZERO;
            done_q      <= ZERO;
            if (in_xfer) begin
                eng_pi_q   <= bus.PI_IN_DATA;
                eng_p_en_q <= ONE;
                eng_i_en_q <= (in_mode == '0);
            end
            if (res_en) begin
                out_vld_q  <= ONE;
                out_data_q <= bus.ENGINE_PI_OUT;
                out_head_q <= out_head;
                out_mode_q <= out_mode;
                if (!all_out) out_cnt_q <= out_cnt_q + CNT_W'(ONE);
            end
            if (fault_now) begin
                state_q    <= FAULT;
                err_q      <= ONE;
                in_ready_q <= ZERO;
                eng_i_en_q <= ZERO;
                eng_p_en_q <= ZERO;
                out_vld_q  <= ZERO;
            end else begin
                case (state_q)
                    IDLE: begin
                        // BUSY is still high on the DONE cycle, which masks a START there.
                        busy_q <= start_acc;
                        if (start_acc) begin
                            err_q     <= ZERO;
                            r_q       <= bus.SIZE_R_IN;
                            target_q  <= (CNT_W'(bus.SIZE_R_IN) << 1) + CNT_W'(bus.SIZE_R_IN);
                            out_cnt_q <= '0;
                            idle_q    <= '0;
                            if (bus.SIZE_R_IN == '0) begin
                                state_q <= FINISH;
                            end else begin
                                state_q     <= KICK;
                                eng_start_q <= ONE;
                            end
                        end
                    end
                    KICK: begin
                        state_q    <= FEED;
                        in_ready_q <= ONE;
                    end
                    FEED: begin
                        if (in_xfer && in_last) begin
                            state_q    <= DRAIN;
                            in_ready_q <= ZERO;
                            idle_q     <= '0;
                        end
                    end
                    DRAIN: begin
                        if (res_en || bus.ENGINE_READY) idle_q <= '0;
                        else                            idle_q <= idle_q + TW'(ONE);
                        if (bus.ENGINE_READY) state_q <= FINISH;
                    end
                    FINISH: begin
                        done_q  <= ONE;
                        state_q <= IDLE;
                    end
                    FAULT: begin
                        busy_q  <= ZERO;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.BUSY               = busy_q;
    assign bus.DONE               = done_q;
    assign bus.ERROR              = err_q;
    assign bus.PI_IN_READY        = in_ready_q;
    assign bus.ENGINE_START       = eng_start_q;
    assign bus.ENGINE_IN_I_ENABLE = eng_i_en_q;
    assign bus.ENGINE_IN_P_ENABLE = eng_p_en_q;
    assign bus.ENGINE_PI_IN       = eng_pi_q;
    assign bus.PI_OUT_VALID       = out_vld_q;
    assign bus.PI_OUT_DATA        = out_data_q;
    assign bus.PI_OUT_HEAD        = out_head_q;
    assign bus.PI_OUT_MODE        = out_mode_q;

endmodule

// File: tb/tb_accelerator_read_modes_scheduler.sv
// Scoreboard bench for the read-modes scheduler: the bench plays both the score source and the engine.
module tb_accelerator_read_modes_scheduler;
    localparam int DS = 64;
    localparam int CS = 64;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    accelerator_read_modes_scheduler_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus ();

    accelerator_read_modes_scheduler #(
        .DATA_SIZE(DS), .CONTROL_SIZE(CS), .TIMEOUT(TO)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    typedef struct {
        logic [DS-1:0] data;
        logic [CS-1:0] head;
        logic [1:0]    mode;
    } out_t;
    typedef struct {
        logic [DS-1:0] data;
        logic          ien;
    } eng_t;

    out_t out_q[$];
    eng_t eng_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_estart = 0, n_ready_hi = 0, n_done = 0, n_pen = 0, n_ien = 0;
    bit   mon_en   = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents an engine element or a result.
    always @(negedge clk) begin
        eng_t e;
        out_t o;
        if (mon_en) begin
            if (bus.ENGINE_START) n_estart++;
            if (bus.PI_IN_READY) n_ready_hi++;
            if (bus.DONE) n_done++;
            if (bus.ENGINE_IN_P_ENABLE) begin
                n_pen++;
                if (bus.ENGINE_IN_I_ENABLE) n_ien++;
                if (eng_q.size() == 0) begin
                    check("eng_unexpected_element", 64'(bus.ENGINE_PI_IN), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = eng_q.pop_front();
                    check("eng_pi_in", 64'(bus.ENGINE_PI_IN), 64'(e.data));
                    check("eng_i_en", 64'(bus.ENGINE_IN_I_ENABLE), 64'(e.ien));
                end
            end else if (bus.ENGINE_IN_I_ENABLE) begin
                check("eng_i_en_without_p", 64'(bus.ENGINE_IN_I_ENABLE), 64'd0);
            end
            if (bus.PI_OUT_VALID) begin
                if (out_q.size() == 0) begin
                    check("out_unexpected_result", 64'(bus.PI_OUT_DATA), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    o = out_q.pop_front();
                    check("out_data", 64'(bus.PI_OUT_DATA), 64'(o.data));
                    check("out_head", 64'(bus.PI_OUT_HEAD), 64'(o.head));
                    check("out_mode", 64'(bus.PI_OUT_MODE), 64'(o.mode));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [DS-1:0] r);
        bus.START     = 1'b1;
        bus.SIZE_R_IN = r;
        tick();
        bus.START     = 1'b0;
    endtask

    task automatic feed(input logic [DS-1:0] d, input logic ien_exp, input bit gap);
        int guard = 0;
        bus.PI_IN_VALID = 1'b1;
        bus.PI_IN_DATA  = d;
        while (!bus.PI_IN_READY && guard < 20) begin
            tick();
            guard++;
        end
        if (!bus.PI_IN_READY) check("feed_ready_timeout", 64'(bus.PI_IN_READY), 64'd1);
        else eng_q.push_back('{d, ien_exp});
        tick();
        bus.PI_IN_VALID = 1'b0;
        if (gap) tick();
    endtask

    task automatic eng_result(input logic [DS-1:0] d, input logic [CS-1:0] h, input logic [1:0] m);
        bus.ENGINE_OUT_P_ENABLE = 1'b1;
        bus.ENGINE_OUT_I_ENABLE = (m == 2'd0);
        bus.ENGINE_PI_OUT       = d;
        out_q.push_back('{d, h, m});
        tick();
        bus.ENGINE_OUT_P_ENABLE = 1'b0;
        bus.ENGINE_OUT_I_ENABLE = 1'b0;
    endtask

    task automatic eng_ready();
        bus.ENGINE_READY = 1'b1;
        tick();
        bus.ENGINE_READY = 1'b0;
    endtask

    task automatic check_reset(string tag);
        check({tag, "_busy"},    64'(bus.BUSY), 64'd0);
        check({tag, "_done"},    64'(bus.DONE), 64'd0);
        check({tag, "_error"},   64'(bus.ERROR), 64'd0);
        check({tag, "_ready"},   64'(bus.PI_IN_READY), 64'd0);
        check({tag, "_estart"},  64'(bus.ENGINE_START), 64'd0);
        check({tag, "_ien"},     64'(bus.ENGINE_IN_I_ENABLE), 64'd0);
        check({tag, "_pen"},     64'(bus.ENGINE_IN_P_ENABLE), 64'd0);
        check({tag, "_epi"},     64'(bus.ENGINE_PI_IN), 64'd0);
        check({tag, "_ovalid"},  64'(bus.PI_OUT_VALID), 64'd0);
        check({tag, "_odata"},   64'(bus.PI_OUT_DATA), 64'd0);
        check({tag, "_ohead"},   64'(bus.PI_OUT_HEAD), 64'd0);
        check({tag, "_omode"},   64'(bus.PI_OUT_MODE), 64'd0);
    endtask

    // Completion of an accepted READY: FINISH next cycle, DONE the cycle after.
    task automatic expect_done_after_ready(string tag);
        check({tag, "_done_early"}, 64'(bus.DONE), 64'd0);
        tick();
        check({tag, "_done"},  64'(bus.DONE), 64'd1);
        check({tag, "_busy"},  64'(bus.BUSY), 64'd1);
        check({tag, "_error"}, 64'(bus.ERROR), 64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(bus.DONE), 64'd0);
        check({tag, "_busy_low"},   64'(bus.BUSY), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_done, b_est, b_rdy, b_pen, b_ien;
        bus.START = 0; bus.SIZE_R_IN = '0; bus.PI_IN_VALID = 0; bus.PI_IN_DATA = '0;
        bus.ENGINE_READY = 0; bus.ENGINE_OUT_I_ENABLE = 0; bus.ENGINE_OUT_P_ENABLE = 0;
        bus.ENGINE_PI_OUT = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // R=2, back-to-back feed, results overlap the tail of the feed.
        b_done = n_done;
        do_start(64'd2);
        check("t1_engine_start", 64'(bus.ENGINE_START), 64'd1);
        check("t1_busy",         64'(bus.BUSY), 64'd1);
        check("t1_ready_kick",   64'(bus.PI_IN_READY), 64'd0);
        fork
            begin
                for (int k = 0; k < 6; k++) feed(64'(k + 1), (k % 3) == 0, 1'b0);
            end
            begin
                repeat (4) tick();
                for (int j = 0; j < 6; j++) eng_result(64'h100 + 64'(j), 64'(j / 3), 2'(j % 3));
            end
        join
        eng_ready();
        expect_done_after_ready("t1");
        check("t1_done_count", 64'(n_done - b_done), 64'd1);
        check("t1_out_drained", 64'(out_q.size()), 64'd0);

        // R=1, PI_IN_VALID toggling.
        b_pen = n_pen; b_ien = n_ien;
        do_start(64'd1);
        feed(64'h7, 1'b1, 1'b1);
        feed(64'h8, 1'b0, 1'b1);
        feed(64'h9, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) eng_result(64'h200 + 64'(j), 64'd0, 2'(j));
        eng_ready();
        expect_done_after_ready("t2");
        check("t2_p_enables", 64'(n_pen - b_pen), 64'd3);
        check("t2_i_enables", 64'(n_ien - b_ien), 64'd1);

        // R=0: no engine activity, DONE two cycles after START.
        b_est = n_estart; b_rdy = n_ready_hi;
        do_start(64'd0);
        check("t3_busy",       64'(bus.BUSY), 64'd1);
        check("t3_done_early", 64'(bus.DONE), 64'd0);
        tick();
        check("t3_done", 64'(bus.DONE), 64'd1);
        tick();
        check("t3_done_pulse",  64'(bus.DONE), 64'd0);
        check("t3_busy_low",    64'(bus.BUSY), 64'd0);
        check("t3_no_estart",   64'(n_estart - b_est), 64'd0);
        check("t3_no_ready",    64'(n_ready_hi - b_rdy), 64'd0);

        // R=2, engine returns only 5 results before READY.
        b_done = n_done;
        do_start(64'd2);
        for (int k = 0; k < 6; k++) feed(64'h10 + 64'(k), (k % 3) == 0, 1'b0);
        for (int j = 0; j < 5; j++) eng_result(64'h300 + 64'(j), 64'(j / 3), 2'(j % 3));
        eng_ready();
        check("t4_error",      64'(bus.ERROR), 64'd1);
        check("t4_busy_fault", 64'(bus.BUSY), 64'd1);
        tick();
        check("t4_busy_low",   64'(bus.BUSY), 64'd0);
        check("t4_error_sticky", 64'(bus.ERROR), 64'd1);
        check("t4_no_done",    64'(n_done - b_done), 64'd0);
        do_start(64'd0);
        check("t4_error_cleared", 64'(bus.ERROR), 64'd0);
        tick();
        check("t4_restart_done", 64'(bus.DONE), 64'd1);
        tick();

        // Engine silent after the feed: ERROR exactly TIMEOUT cycles after the last transfer.
        do_start(64'd1);
        for (int k = 0; k < 3; k++) feed(64'h20 + 64'(k), k == 0, 1'b0);
        repeat (TO - 1) tick();
        check("t5_error_early", 64'(bus.ERROR), 64'd0);
        tick();
        check("t5_error_timeout", 64'(bus.ERROR), 64'd1);
        tick();
        check("t5_busy_low", 64'(bus.BUSY), 64'd0);

        // RST while element 3 is offered, then a clean R=1 job.
        do_start(64'd2);
        for (int k = 0; k < 3; k++) feed(64'h30 + 64'(k), k == 0, 1'b0);
        bus.PI_IN_VALID = 1'b1;
        bus.PI_IN_DATA  = 64'h33;
        rst = 1'b1;
        tick();
        check_reset("t6_midreset");
        rst = 1'b0;
        bus.PI_IN_VALID = 1'b0;
        check("t6_eng_queue_empty", 64'(eng_q.size()), 64'd0);
        tick();
        do_start(64'd1);
        for (int k = 0; k < 3; k++) feed(64'h40 + 64'(k), k == 0, 1'b0);
        for (int j = 0; j < 3; j++) eng_result(64'h400 + 64'(j), 64'd0, 2'(j));
        eng_ready();
        expect_done_after_ready("t6");

        tick();
        check("end_out_queue", 64'(out_q.size()), 64'd0);
        check("end_eng_queue", 64'(eng_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
